// File: rtl/tpg_sched_pkg.sv
// Shared types and constants for the traffic-generator injection scheduler.
package tpg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A flit limit of zero means the scheduler never runs out of budget.
  localparam int unsigned LIMIT_UNLIMITED = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational K-way round-robin select: first asserted req at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned K  = 4,
  parameter int unsigned IW = $clog2(K)
) (
  input  logic [K-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int o = int'(K) - 1; o >= 0; o--) begin
      sel = IW'((int'(ptr) + o) % int'(K));
      if (req[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/tpg_inject_arb.sv
// Round-robin injection scheduler sharing one router input port between K generators,
// with bounded bursts, a single-entry output register and a global flit budget.
module tpg_inject_arb
  import tpg_sched_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned N            = 16,
  parameter int unsigned N_ADDR_WIDTH = $clog2(N),
  parameter int unsigned K            = 4,
  parameter int unsigned BURST        = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CNT_WIDTH-1:0]      flit_limit,
  input  logic [K*WIDTH-1:0]        req_data,
  input  logic [K*N_ADDR_WIDTH-1:0] req_dest,
  input  logic [K-1:0]              req_valid,
  output logic [K-1:0]              req_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic [N_ADDR_WIDTH-1:0]   dest_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [$clog2(K)-1:0]      grant_id,
  output logic [CNT_WIDTH-1:0]      sent_count,
  output logic                      done
);

  localparam int unsigned GW = $clog2(K);
  localparam int unsigned BW = $clog2(BURST + 1);

  state_t               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] limit_q, limit_d;
  logic [CNT_WIDTH-1:0] acc_inc;
  logic [CNT_WIDTH-1:0] sent_d;
  logic                 valid_d;
  logic                 done_d;
  logic                 stage_free;
  logic                 budget_hit;
  logic                 hit_next;
  logic                 accept;
  logic                 xfer;
  logic                 grant_end;
  logic                 pick_found;
  logic [GW-1:0]        pick_idx;

  rr_pick #(
    .K  (K),
    .IW (GW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign stage_free = !valid_out || ready_in;
  assign xfer       = valid_out && ready_in;
  assign budget_hit = (limit_q != CNT_WIDTH'(LIMIT_UNLIMITED)) && (acc_q == limit_q);
  assign acc_inc    = acc_q + CNT_WIDTH'(1);

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && stage_free && !budget_hit) req_ready[grant_id] = 1'b1;
  end

  assign accept   = req_valid[grant_id] && req_ready[grant_id];
  assign hit_next = accept && (limit_q != CNT_WIDTH'(LIMIT_UNLIMITED)) && (acc_inc == limit_q);

  // Next-state, counters and output-stage next values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_id;
    burst_d   = burst_q;
    acc_d     = acc_q;
    limit_d   = limit_q;
    grant_end = 1'b0;

    if (accept) begin
      acc_d   = acc_inc;
      burst_d = burst_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        limit_d = flit_limit;
        acc_d   = '0;
        burst_d = '0;
        if (enable) state_d = ARB;
      end
      ARB: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (budget_hit) begin
          state_d = DONE;
        end else if (pick_found) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!enable) begin
          state_d   = IDLE;
          grant_end = 1'b1;
        end else if (hit_next || budget_hit) begin
          state_d   = DONE;
          grant_end = 1'b1;
        end else if ((accept && burst_q == BW'(BURST - 1)) ||
                     (!req_valid[grant_id] && stage_free)) begin
          state_d   = ARB;
          grant_end = 1'b1;
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_end) ptr_d = (grant_id == GW'(K - 1)) ? '0 : grant_id + GW'(1);

    if (state_q == IDLE)                 sent_d = '0;
    else if (xfer && sent_count != '1)   sent_d = sent_count + CNT_WIDTH'(1);
    else                                 sent_d = sent_count;

    if (accept)        valid_d = 1'b1;
    else if (ready_in) valid_d = 1'b0;
    else               valid_d = valid_out;

    done_d = (state_d == DONE) && !valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id   <= '0;
      burst_q    <= '0;
      acc_q      <= '0;
      limit_q    <= '0;
      sent_count <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      dest_out   <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id   <= grant_d;
      burst_q    <= burst_d;
      acc_q      <= acc_d;
      limit_q    <= limit_d;
      sent_count <= sent_d;
      valid_out  <= valid_d;
      done       <= done_d;
      if (accept) begin
        data_out <= req_data[32'(grant_id) * WIDTH +: WIDTH];
        dest_out <= req_dest[32'(grant_id) * N_ADDR_WIDTH +: N_ADDR_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tpg_inject_arb.sv
// Self-checking bench for tpg_inject_arb: vector table, directed corner sequences and a
// randomized run scored against a flit-order / budget model.
module tb_tpg_inject_arb;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned NA    = 4;
  localparam int unsigned K     = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned CW    = 16;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [CW-1:0]     flit_limit;
  logic [K*WIDTH-1:0] req_data;
  logic [K*NA-1:0]   req_dest;
  logic [K-1:0]      req_valid;
  logic [K-1:0]      req_ready;
  logic [WIDTH-1:0]  data_out;
  logic [NA-1:0]     dest_out;
  logic              valid_out;
  logic              ready_in;
  logic [1:0]        grant_id;
  logic [CW-1:0]     sent_count;
  logic              done;

  tpg_inject_arb #(
    .WIDTH(WIDTH), .N(N), .N_ADDR_WIDTH(NA), .K(K), .BURST(BURST), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flit_limit(flit_limit),
    .req_data(req_data), .req_dest(req_dest), .req_valid(req_valid), .req_ready(req_ready),
    .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out), .ready_in(ready_in),
    .grant_id(grant_id), .sent_count(sent_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    int          src;
  } flit_t;

  typedef struct {
    logic        en;
    logic [3:0]  rv;
    logic        rdy;
    logic [3:0]  rr;
    logic        vo;
    logic [1:0]  gid;
    logic [15:0] sent;
  } vec_t;

  flit_t sb[$];
  int    acc_log[$];
  int    seq[K];
  int    tests = 0;
  int    fails = 0;
  int    sent_model = 0;
  int    acc_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic refresh();
    for (int i = 0; i < int'(K); i++) begin
      req_data[i*WIDTH +: WIDTH] = {8'(i + 1), 8'h5A, 16'(seq[i])};
      req_dest[i*NA +: NA]       = 4'(i * 5 + seq[i]);
    end
  endtask

  // Called just after inputs settle: scores this cycle's handshakes, then advances one clock.
  task automatic tick();
    logic [K-1:0] acc;
    logic         xf;
    flit_t        f;
    acc = req_valid & req_ready;
    xf  = valid_out && ready_in;
    chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (xf) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL flit_extra: got flit %0h expected none", data_out);
      end else begin
        f = sb.pop_front();
        chk("flit_data", data_out, f.data);
        chk("flit_dest", 32'(dest_out), 32'(f.dest));
      end
      sent_model++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(K); i++) begin
      if (acc[i]) begin
        f.data = req_data[i*WIDTH +: WIDTH];
        f.dest = req_dest[i*NA +: NA];
        f.src  = i;
        sb.push_back(f);
        acc_log.push_back(i);
        seq[i]++;
        acc_total++;
      end
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    tick();
  endtask

  vec_t        tbl[14];
  logic [31:0] snap_d;
  logic [15:0] snap_s;
  logic [31:0] hd;
  logic [3:0]  hdst;
  bit          hold;
  bit          fin;
  int          nx;
  int          lim;

  initial begin
    rst = 1'b1; enable = 1'b0; flit_limit = '0; req_valid = '0; ready_in = 1'b1;
    for (int i = 0; i < int'(K); i++) seq[i] = 0;
    refresh();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_dest_out", 32'(dest_out), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_sent_count", 32'(sent_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All requesters valid, unlimited budget: 4-flit bursts with one bubble per re-arbitration.
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 16'd0};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd0};
    tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd1};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'd2};
    tbl[6]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 16'd3};
    tbl[7]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b0, 2'd1, 16'd4};
    tbl[8]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd4};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd5};
    tbl[10] = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'd6};
    tbl[11] = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 16'd7};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b0, 2'd2, 16'd8};
    tbl[13] = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'd8};
    acc_log.delete();
    for (int r = 0; r < 14; r++) begin
      enable = tbl[r].en; req_valid = tbl[r].rv; ready_in = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", r), 32'(req_ready), 32'(tbl[r].rr));
      chk($sformatf("tbl%0d_valid_out", r), 32'(valid_out), 32'(tbl[r].vo));
      chk($sformatf("tbl%0d_grant_id", r), 32'(grant_id), 32'(tbl[r].gid));
      chk($sformatf("tbl%0d_sent", r), 32'(sent_count), 32'(tbl[r].sent));
      tick();
    end
    repeat (13) cyc();
    #1;
    chk("rr_sent_after_25", 32'(sent_count), 32'd20);
    chk("rr_accept_total", 32'(acc_log.size()), 32'd20);
    for (int k = 0; k < acc_log.size() && k < 20; k++)
      chk($sformatf("rr_order_%0d", k), 32'(acc_log[k]), 32'((k / 4) % 4));

    // Budget of 5 with only requester 2 valid.
    enable = 1'b0; req_valid = '0;
    tick();
    repeat (4) cyc();
    flit_limit = 16'd5; req_valid = 4'b0100; enable = 1'b1;
    acc_log.delete();
    nx = 0; fin = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (nx == 5) begin
        chk("lim_done_rise", 32'(done), 32'd1);
        chk("lim_rr_after_done", 32'(req_ready), 32'd0);
        chk("lim_valid_after_done", 32'(valid_out), 32'd0);
        fin = 1;
        tick();
        break;
      end
      chk("lim_done_early", 32'(done), 32'd0);
      if (valid_out && ready_in) nx++;
      tick();
    end
    if (!fin) timeout_fail("lim_done_wait");
    chk("lim_accepts", 32'(acc_log.size()), 32'd5);
    foreach (acc_log[k]) chk("lim_src", 32'(acc_log[k]), 32'd2);
    repeat (3) begin
      #1;
      chk("lim_rr_hold", 32'(req_ready), 32'd0);
      chk("lim_done_hold", 32'(done), 32'd1);
      tick();
    end
    #1;
    chk("lim_sent", 32'(sent_count), 32'd5);
    tick();

    // Backpressure mid-burst for 10 cycles.
    enable = 1'b0; req_valid = '0;
    repeat (3) cyc();
    flit_limit = '0; req_valid = 4'hF; enable = 1'b1; sent_model = 0;
    repeat (4) cyc();
    ready_in = 1'b0;
    #1;
    snap_d = data_out; snap_s = sent_count;
    chk("bp_valid_start", 32'(valid_out), 32'd1);
    tick();
    repeat (9) begin
      #1;
      chk("bp_data_stable", data_out, snap_d);
      chk("bp_valid_stable", 32'(valid_out), 32'd1);
      chk("bp_rr_zero", 32'(req_ready), 32'd0);
      chk("bp_sent_stable", 32'(sent_count), 32'(snap_s));
      tick();
    end
    ready_in = 1'b1;
    repeat (8) cyc();
    #1;
    chk("bp_sent_total", 32'(sent_count), 32'(sent_model));
    tick();

    // Requester 1 drops after two flits; next grant searches from 2 with wrap.
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    rst = 1'b0;
    enable = 1'b1; req_valid = 4'b0010;
    repeat (4) cyc();
    req_valid = 4'b1001;
    cyc();
    #1;
    chk("drop_gid_prev", 32'(grant_id), 32'd1);
    chk("drop_bubble_rr", 32'(req_ready), 32'd0);
    tick();
    #1;
    chk("drop_next_rr", 32'(req_ready), 32'h8);
    chk("drop_next_gid", 32'(grant_id), 32'd3);
    tick();

    // enable dropped in GRANT with a flit stuck behind ready_in=0.
    enable = 1'b0; req_valid = '0;
    repeat (3) cyc();
    req_valid = 4'b0001; enable = 1'b1;
    repeat (3) cyc();
    ready_in = 1'b0; enable = 1'b0;
    #1;
    snap_d = data_out;
    chk("dis_valid_pending", 32'(valid_out), 32'd1);
    chk("dis_rr_zero", 32'(req_ready), 32'd0);
    tick();
    repeat (5) begin
      #1;
      chk("dis_valid_held", 32'(valid_out), 32'd1);
      chk("dis_data_held", data_out, snap_d);
      chk("dis_rr_held", 32'(req_ready), 32'd0);
      chk("dis_sent_zero", 32'(sent_count), 32'd0);
      tick();
    end
    ready_in = 1'b1;
    #1;
    chk("dis_valid_last", 32'(valid_out), 32'd1);
    tick();
    #1;
    chk("dis_valid_drained", 32'(valid_out), 32'd0);
    tick();
    enable = 1'b1;
    #1;
    chk("reen_sent_zero", 32'(sent_count), 32'd0);
    tick();
    repeat (3) cyc();
    #1;
    chk("reen_sent_one", 32'(sent_count), 32'd1);
    tick();

    // Asynchronous reset between edges, mid-burst.
    req_valid = 4'hF;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid_out", 32'(valid_out), 32'd0);
    chk("arst_data_out", data_out, 32'd0);
    chk("arst_dest_out", 32'(dest_out), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_sent", 32'(sent_count), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cyc();
    #1;
    chk("arst_resume_rr", 32'(req_ready), 32'h1);
    chk("arst_resume_gid", 32'(grant_id), 32'd0);
    tick();

    // Randomized traffic against the flit-order and budget model.
    enable = 1'b0; req_valid = '0; ready_in = 1'b1;
    repeat (4) cyc();
    lim = int'($urandom_range(20, 60));
    flit_limit = 16'(lim); enable = 1'b1; sent_model = 0; acc_total = 0;
    hold = 0; fin = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      ready_in  = ($urandom % 4) != 0;
      #1;
      if (hold) begin
        chk("rnd_hold_data", data_out, hd);
        chk("rnd_hold_dest", 32'(dest_out), 32'(hdst));
        chk("rnd_hold_valid", 32'(valid_out), 32'd1);
      end
      hold = valid_out && !ready_in;
      hd = data_out; hdst = dest_out;
      if (hold) chk("rnd_bp_rr", 32'(req_ready), 32'd0);
      chk("rnd_sent", 32'(sent_count), 32'(sent_model));
      chk("rnd_budget", 32'(acc_total <= lim), 32'd1);
      if (done) begin
        chk("rnd_total", 32'(acc_total), 32'(lim));
        chk("rnd_drained", 32'(valid_out), 32'd0);
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);
        fin = 1;
        tick();
        break;
      end
      tick();
    end
    if (!fin) timeout_fail("rnd_done_wait");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpg_inject_arb.md
# tpg_inject_arb

Round-robin injection scheduler that shares one NoC router input port between K traffic generators. It grants one requester at a time for a bounded burst and registers the granted flit into a single-entry output stage. It enforces a global flit budget and reports completion. It sits between a cluster of traffic generators and the router port, taking the place of a direct generator-to-router connection.

## Interface
- WIDTH, 32, flit data width
- N, 16, number of NoC nodes
- N_ADDR_WIDTH, $clog2(N), router address width
- K, 4, number of requesters (≥2)
- BURST, 4, max consecutive flits accepted per grant (≥1)
- CNT_WIDTH, 16, width of budget/count

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  run control; sampled every cycle
- flit_limit  in  CNT_WIDTH  total flits to send; 0 = unlimited; only sampled in IDLE
- req_data  in  K*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- req_dest  in  K*N_ADDR_WIDTH  requester i destination
- req_valid  in  K  requester i has a flit
- req_ready  out  K  one-hot accept strobe to requester i
- data_out  out  WIDTH  flit to router
- dest_out  out  N_ADDR_WIDTH  destination to router
- valid_out  out  1  flit valid to router
- ready_in  in  1  router can accept
- grant_id  out  $clog2(K)  current/last granted requester
- sent_count  out  CNT_WIDTH  flits handshaken on output since leaving IDLE
- done  out  1  budget exhausted and output drained

## Operation
- Input transfer: req_valid[i] && req_ready[i]. Output transfer: valid_out && ready_in.
- The output stage is one register. It is free when !valid_out || ready_in.
- req_ready[g] = (state==GRANT) && (g==grant) && stage free && !budget_hit. At most one bit is high at a time.
- FSM states are IDLE, ARB, GRANT and DONE.
  - IDLE: latch flit_limit and clear sent_count, accepted count and burst count. Go to ARB when enable=1.
  - ARB: search req_valid round-robin from ptr (ptr = last grant+1 mod K). If a requester is found, load grant and go to GRANT. If none is found, stay in ARB. If enable=0, go to IDLE.
  - GRANT: each accepted flit increments burst_cnt and accepted count. The grant ends and the FSM returns to ARB after BURST accepts, or in any cycle where req_valid[grant]=0 while the stage is free. On grant end, ptr = grant+1 mod K. If enable=0, the FSM goes to IDLE after the current cycle's accept.
  - When accepted count == limit (limit≠0), no further accepts occur; go to DONE.
  - DONE: done=1 once valid_out=0. Stay in DONE until enable=0, then go to IDLE.
- sent_count increments on each output transfer and saturates at all-ones.
- Counter widths: the accepted and sent counts are CNT_WIDTH bits. The unlimited mode (limit=0) never reaches DONE, and its counts wrap (sent_count saturates).
- Leaving GRANT for IDLE does not flush the stage. A pending flit is held until ready_in.

## Timing
- Reset values: valid_out=0, data_out=0, dest_out=0, req_ready=0, grant_id=0, sent_count=0, done=0, state=IDLE, ptr=0.
- Latency:
  - enable rising to the first possible req_ready is 2 cycles (IDLE→ARB→GRANT).
  - A flit is accepted at edge t and appears on data_out/dest_out with valid_out=1 after edge t (1 cycle).
- Throughput is 1 flit/cycle within a grant while ready_in=1. Each re-arbitration costs 1 bubble cycle.
- Backpressure: with ready_in=0 and valid_out=1, data_out, dest_out and valid_out are held stable and req_ready=0.
- Simultaneous output drain and input accept in the same cycle is allowed, giving back-to-back flits.
- Reset asserted mid-burst clears all state immediately. Any pending flit is dropped.

## Structure
- Package tpg_sched_pkg: state enum (IDLE, ARB, GRANT, DONE) and the unlimited-limit constant 0.
- Sub-module rr_pick: combinational K-way round-robin select with inputs req and ptr and outputs found and idx. It is instantiated once.

## Test plan
- K=4, all requesters valid, ready_in=1, BURST=4, limit=0: grants follow 0,1,2,3,0. Each grant gives 4 consecutive flits, then 1 idle cycle. sent_count=20 after 25 output cycles.
- Only requester 2 valid, limit=5: all 5 flits come from requester 2 with dest values preserved. done rises the cycle after the 5th output transfer, and req_ready stays 0 afterward.
- ready_in held 0 for 10 cycles mid-burst: data_out is stable, req_ready=0, and there is no loss or duplication. sent_count is unchanged until ready_in=1.
- Requester 1 drops req_valid after 2 of 4 flits: the grant ends and ptr=2. The next grant goes to the lowest valid index ≥2 with wrap.
- enable deasserted in GRANT with a flit pending and ready_in=0: the FSM reaches IDLE and valid_out stays 1 until ready_in=1, then goes 0. Re-enable restarts sent_count at 0.
- rst pulsed asynchronously mid-burst, between clock edges: all outputs reach their reset values before the next edge, and operation resumes from IDLE.
